// File: rtl/branch_pkg.sv
// Shared constants and result-slot flag bundle for the control-transfer stage.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef struct packed {
        logic taken;
        logic redirect;
        logic rd_we;
        logic misalign;
        logic illegal;
    } slot_flags_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: funct3 plus operands -> taken / illegal.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = rs1 == rs2;
    assign lt  = $signed(rs1) < $signed(rs2);
    assign ltu = rs1 < rs2;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_exec_unit.sv
// Branch/JAL/JALR execute stage with a one-entry registered result slot.
// Optional saturating statistics counters under BRANCH_STATS_EN.
module branch_exec_unit
    import branch_pkg::*;
#(
    parameter int XLEN = 32
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_rd_val,
    output logic            out_misalign,
    output logic            out_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic            is_jump;
    logic            cmp_taken;
    logic            cmp_illegal;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] n_rpc;
    logic [XLEN-1:0] n_rdv;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] rdv;
    slot_flags_t     nf;
    slot_flags_t     slot;
    logic            accept;
    logic            load;

    assign is_br   = in_op == OP_BRANCH;
    assign is_jal  = in_op == OP_JAL;
    assign is_jalr = in_op == OP_JALR;
    assign is_jump = is_jal || is_jalr;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (in_funct3),
        .rs1     (in_rs1_val),
        .rs2     (in_rs2_val),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // One adder serves both target forms; bit 0 is cleared only for JALR.
    assign base   = is_jalr ? in_rs1_val : in_pc;
    assign target = (base + in_imm) & ~XLEN'(is_jalr);
    assign link   = in_pc + XLEN'(4);

    always_comb begin
        nf          = '0;
        nf.illegal  = !(is_br || is_jump) || (is_br && cmp_illegal);
        nf.taken    = !nf.illegal && (is_jump || cmp_taken);
        nf.rd_we    = !nf.illegal && is_jump;
        nf.misalign = nf.taken && (target[1:0] != 2'b00);
        nf.redirect = !nf.illegal && !nf.misalign &&
                      ((nf.taken != in_pred_taken) ||
                       (nf.taken && (target != in_pred_target)));
        n_rpc = nf.redirect ? (nf.taken ? target : link) : '0;
        n_rdv = nf.rd_we ? link : '0;
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !flush;

    // Empty slot always carries all-zero fields.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            slot      <= '0;
            rpc       <= '0;
            rdv       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            slot      <= nf;
            rpc       <= n_rpc;
            rdv       <= n_rdv;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            slot      <= '0;
            rpc       <= '0;
            rdv       <= '0;
        end
    end

    assign out_taken       = slot.taken;
    assign out_redirect    = slot.redirect;
    assign out_rd_we       = slot.rd_we;
    assign out_misalign    = slot.misalign;
    assign out_illegal     = slot.illegal;
    assign out_redirect_pc = rpc;
    assign out_rd_val      = rdv;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (load) begin
            if (!nf.illegal && (stat_branches != '1))
                stat_branches <= stat_branches + CNT_W'(1);
            if (nf.redirect && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
        end
    end
`endif

endmodule
